// File: rtl/board_io_frontend.sv
// rtl/board_io_frontend.sv - board glue: reset sequencer, button debounce/IRQ, switch sync, LED register
//
// Purpose
//    Sits between the FPGA pins / clock generator and the SoC. It holds the SoC in reset
//    until the board reset button is released and the PLL is locked for a full hold-off
//    period. It debounces the push-buttons into level, rise-pulse and sticky IRQ outputs,
//    synchronises the switches and registers the LED drive.
//
// Ports
//    clk_i          system clock (PLL output)
//    srstn_i        synchronous active-low reset
//    ext_rstn_i     raw board reset button, active-low, asynchronous
//    pll_locked_i   PLL lock, asynchronous
//    btn_i          raw buttons, active-high, asynchronous
//    sw_i           raw switches, asynchronous
//    irq_en_i       per-button IRQ enable
//    irq_ack_i      per-button pending clear, 1-cycle pulse
//    led_i          LED value from SoC GPIO
//    sys_rst_o      active-high SoC reset
//    btn_level_o    debounced button level
//    btn_rise_o     1-cycle pulse on debounced 0->1
//    irq_pend_o     sticky pending flags
//    irq_o          OR of irq_pend_o
//    sw_o           synchronised switches
//    led_o          registered LED drive

module board_io_frontend #(
   parameter int BTN_NUM         = 5,
   parameter int SW_WIDTH        = 16,
   parameter int LED_WIDTH       = 16,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 100000,
   parameter int RST_HOLD_CYCLES = 1024
) (
   input  logic                 clk_i,
   input  logic                 srstn_i,
   input  logic                 ext_rstn_i,
   input  logic                 pll_locked_i,
   input  logic [BTN_NUM-1:0]   btn_i,
   input  logic [SW_WIDTH-1:0]  sw_i,
   input  logic [BTN_NUM-1:0]   irq_en_i,
   input  logic [BTN_NUM-1:0]   irq_ack_i,
   input  logic [LED_WIDTH-1:0] led_i,
   output logic                 sys_rst_o,
   output logic [BTN_NUM-1:0]   btn_level_o,
   output logic [BTN_NUM-1:0]   btn_rise_o,
   output logic [BTN_NUM-1:0]   irq_pend_o,
   output logic                 irq_o,
   output logic [SW_WIDTH-1:0]  sw_o,
   output logic [LED_WIDTH-1:0] led_o
);

   localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int RH_W   = $clog2(RST_HOLD_CYCLES + 1);
   localparam int SYNC_W = 2 + BTN_NUM + SW_WIDTH;

   typedef enum logic [1:0] {
      ST_HOLD,
      ST_COUNT,
      ST_RUN
   } rst_state_t;

   // All asynchronous inputs share one multi-stage synchroniser, packed as
   // {ext_rstn, pll_locked, btn, sw}.
   logic [SYNC_W-1:0]  sync_q [SYNC_STAGES];
   logic [SYNC_W-1:0]  sync_out;
   logic               ext_rstn_s;
   logic               pll_locked_s;
   logic [BTN_NUM-1:0] btn_s;
   logic               src_ok;

   always_ff @(posedge clk_i) begin
      if (!srstn_i) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         sync_q[0] <= {ext_rstn_i, pll_locked_i, btn_i, sw_i};
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign sync_out     = sync_q[SYNC_STAGES-1];
   assign ext_rstn_s   = sync_out[SYNC_W-1];
   assign pll_locked_s = sync_out[SYNC_W-2];
   assign btn_s        = sync_out[SW_WIDTH +: BTN_NUM];
   assign sw_o         = sync_out[SW_WIDTH-1:0];
   assign src_ok       = ext_rstn_s & pll_locked_s;

   // Reset sequencer
   rst_state_t      state_q, state_d;
   logic [RH_W-1:0] hold_cnt_q, hold_cnt_d;

   always_ff @(posedge clk_i) begin
      if (!srstn_i) begin
         state_q    <= ST_HOLD;
         hold_cnt_q <= '0;
         sys_rst_o  <= 1'b1;
      end else begin
         state_q    <= state_d;
         hold_cnt_q <= hold_cnt_d;
         // Registered from the current state, so the release lands one edge after RUN.
         sys_rst_o  <= (state_q != ST_RUN);
      end
   end

   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      case (state_q)
         ST_HOLD: begin
            if (src_ok) begin
               state_d    = ST_COUNT;
               hold_cnt_d = '0;
            end
         end
         ST_COUNT: begin
            if (!src_ok) begin
               state_d    = ST_HOLD;
               hold_cnt_d = '0;
            end else begin
               hold_cnt_d = hold_cnt_q + RH_W'(1);
               if (hold_cnt_q == RH_W'(RST_HOLD_CYCLES - 1)) begin
                  state_d = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            if (!src_ok) begin
               state_d = ST_HOLD;
            end
         end
         default: begin
            state_d    = ST_HOLD;
            hold_cnt_d = '0;
         end
      endcase
   end

   // Debouncers: independent of sys_rst_o so a held button is already stable at release.
   logic [BTN_NUM-1:0] level_q;
   logic [BTN_NUM-1:0] level_prev_q;
   logic [DB_W-1:0]    db_cnt_q [BTN_NUM];

   always_ff @(posedge clk_i) begin
      if (!srstn_i) begin
         level_q      <= '0;
         level_prev_q <= '0;
         for (int i = 0; i < BTN_NUM; i++) begin
            db_cnt_q[i] <= '0;
         end
      end else begin
         level_prev_q <= level_q;
         for (int i = 0; i < BTN_NUM; i++) begin
            if (btn_s[i] == level_q[i]) begin
               db_cnt_q[i] <= '0;
            end else if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
               level_q[i]  <= btn_s[i];
               db_cnt_q[i] <= '0;
            end else begin
               db_cnt_q[i] <= db_cnt_q[i] + DB_W'(1);
            end
         end
      end
   end

   assign btn_level_o = level_q;
   assign btn_rise_o  = level_q & ~level_prev_q & {BTN_NUM{~sys_rst_o}};

   // Pending flags: a new rise wins over a simultaneous ack so no event is lost.
   logic [BTN_NUM-1:0] pend_d;

   always_comb begin
      pend_d = '0;
      if (!sys_rst_o) begin
         pend_d = (irq_pend_o & ~irq_ack_i) | (btn_rise_o & irq_en_i);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!srstn_i) begin
         irq_pend_o <= '0;
         irq_o      <= 1'b0;
         led_o      <= '0;
      end else begin
         irq_pend_o <= pend_d;
         irq_o      <= |pend_d;
         led_o      <= sys_rst_o ? '0 : led_i;
      end
   end

endmodule

// File: tb/tb_board_io_frontend.sv
// tb/tb_board_io_frontend.sv - scoreboard bench for board_io_frontend

module tb_board_io_frontend;

   localparam int BTN  = 5;
   localparam int SW   = 16;
   localparam int LED  = 16;
   localparam int SYNC = 2;
   localparam int DEB  = 8;
   localparam int HOLD = 16;

   logic           clk;
   logic           srstn_i;
   logic           ext_rstn_i;
   logic           pll_locked_i;
   logic [BTN-1:0] btn_i;
   logic [SW-1:0]  sw_i;
   logic [BTN-1:0] irq_en_i;
   logic [BTN-1:0] irq_ack_i;
   logic [LED-1:0] led_i;
   logic           sys_rst_o;
   logic [BTN-1:0] btn_level_o;
   logic [BTN-1:0] btn_rise_o;
   logic [BTN-1:0] irq_pend_o;
   logic           irq_o;
   logic [SW-1:0]  sw_o;
   logic [LED-1:0] led_o;

   board_io_frontend #(
      .BTN_NUM(BTN), .SW_WIDTH(SW), .LED_WIDTH(LED), .SYNC_STAGES(SYNC),
      .DEBOUNCE_CYCLES(DEB), .RST_HOLD_CYCLES(HOLD)
   ) dut (
      .clk_i(clk), .srstn_i(srstn_i), .ext_rstn_i(ext_rstn_i), .pll_locked_i(pll_locked_i),
      .btn_i(btn_i), .sw_i(sw_i), .irq_en_i(irq_en_i), .irq_ack_i(irq_ack_i), .led_i(led_i),
      .sys_rst_o(sys_rst_o), .btn_level_o(btn_level_o), .btn_rise_o(btn_rise_o),
      .irq_pend_o(irq_pend_o), .irq_o(irq_o), .sw_o(sw_o), .led_o(led_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct packed {
      logic           sys_rst;
      logic [BTN-1:0] level;
      logic [BTN-1:0] rise;
      logic [BTN-1:0] pend;
      logic           irq;
      logic [SW-1:0]  sw;
      logic [LED-1:0] led;
   } exp_t;

   typedef struct packed {
      logic           ext;
      logic           pll;
      logic [BTN-1:0] btn;
      logic [SW-1:0]  sw;
   } raw_t;

   exp_t exp_q[$];

   // Reference model: inputs reach the logic SYNC edges late; the SoC is released once the
   // reset sources have been good for HOLD+1 consecutive edges (one more edge for the output
   // register); a button level flips once the last DEB synchronised samples all disagree.
   raw_t           line[$];
   logic [BTN-1:0] bhist[$];
   int             ok_run;
   logic           m_sys_rst;
   logic [BTN-1:0] m_level, m_rise, m_pend, m_new_level, m_new_pend;
   logic           m_new_sys_rst, m_all_diff;
   raw_t           m_pre;
   exp_t           m_e;

   initial begin
      forever begin
         @(posedge clk);
         m_e = '0;
         if (!srstn_i) begin
            line.delete();
            for (int i = 0; i < SYNC; i++) line.push_back('0);
            bhist.delete();
            ok_run    = 0;
            m_sys_rst = 1'b1;
            m_level   = '0;
            m_rise    = '0;
            m_pend    = '0;
            m_e.sys_rst = 1'b1;
         end else begin
            m_pre = line[SYNC-1];
            line.push_front({ext_rstn_i, pll_locked_i, btn_i, sw_i});
            void'(line.pop_back());
            m_new_sys_rst = !(ok_run >= HOLD + 1);
            if (m_pre.ext && m_pre.pll) begin
               if (ok_run < 1000000) ok_run++;
            end else begin
               ok_run = 0;
            end
            bhist.push_back(m_pre.btn);
            if (bhist.size() > DEB) void'(bhist.pop_front());
            m_new_level = m_level;
            for (int b = 0; b < BTN; b++) begin
               if (bhist.size() == DEB) begin
                  m_all_diff = 1'b1;
                  for (int k = 0; k < bhist.size(); k++)
                     if (bhist[k][b] == m_level[b]) m_all_diff = 1'b0;
                  if (m_all_diff) m_new_level[b] = ~m_level[b];
               end
            end
            m_new_pend = m_sys_rst ? '0 : ((m_pend & ~irq_ack_i) | (m_rise & irq_en_i));
            m_e.led    = m_sys_rst ? '0 : led_i;
            m_rise     = m_new_level & ~m_level & {BTN{~m_new_sys_rst}};
            m_level    = m_new_level;
            m_sys_rst  = m_new_sys_rst;
            m_pend     = m_new_pend;
            m_e.sys_rst = m_sys_rst;
            m_e.level   = m_level;
            m_e.rise    = m_rise;
            m_e.pend    = m_pend;
            m_e.irq     = |m_pend;
            m_e.sw      = line[SYNC-1].sw;
         end
         exp_q.push_back(m_e);
      end
   end

   // Monitor: compares every cycle's outputs against the next queued expectation.
   int   edge_idx  = -1;
   int   fall_edge = -1;
   logic fall_seen = 1'b0;
   int   rise0_cnt = 0;
   logic mon_rst;
   exp_t mon_e;

   initial begin
      forever begin
         @(posedge clk);
         mon_rst = !srstn_i;
         #1;
         if (mon_rst) begin
            edge_idx  = -1;
            fall_seen = 1'b0;
            fall_edge = -1;
         end else begin
            edge_idx++;
            if (!fall_seen && sys_rst_o === 1'b0) begin
               fall_seen = 1'b1;
               fall_edge = edge_idx;
            end
         end
         if (btn_rise_o[0] === 1'b1) rise0_cnt++;
         if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
         end else begin
            mon_e = exp_q.pop_front();
            chk("sys_rst_o",   32'(sys_rst_o),   32'(mon_e.sys_rst));
            chk("btn_level_o", 32'(btn_level_o), 32'(mon_e.level));
            chk("btn_rise_o",  32'(btn_rise_o),  32'(mon_e.rise));
            chk("irq_pend_o",  32'(irq_pend_o),  32'(mon_e.pend));
            chk("irq_o",       32'(irq_o),       32'(mon_e.irq));
            chk("sw_o",        32'(sw_o),        32'(mon_e.sw));
            chk("led_o",       32'(led_o),       32'(mon_e.led));
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_release(input int limit);
      for (int i = 0; i < limit && !fall_seen; i++) cyc(1);
   endtask

   task automatic wait_sys_rst_low(input int limit);
      for (int i = 0; i < limit && sys_rst_o !== 1'b0; i++) cyc(1);
      chk("sys_rst_low_reached", 32'(sys_rst_o), 32'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   logic got_rise;

   initial begin
      srstn_i = 1'b0; ext_rstn_i = 1'b0; pll_locked_i = 1'b0;
      btn_i = '0; sw_i = '0; irq_en_i = '0; irq_ack_i = '0; led_i = '0;
      cyc(3);

      // T1 / T5: sources good from edge 0, release at edge SYNC+HOLD+1
      ext_rstn_i = 1'b1; pll_locked_i = 1'b1; sw_i = 16'hA5C3; led_i = 16'h00FF;
      srstn_i = 1'b1;
      cyc(2);
      chk("t5_sw_after_2", 32'(sw_o), 32'hA5C3);
      wait_release(40);
      chk("t1_fall_edge", 32'(fall_edge), 32'd19);
      chk("t5_led_during_rst", 32'(led_o), 32'h0);
      cyc(1);
      chk("t5_led_after", 32'(led_o), 32'h00FF);

      // T2: one-cycle PLL glitch in COUNT restarts the hold, drop in RUN re-asserts reset
      srstn_i = 1'b0; cyc(2); srstn_i = 1'b1;
      cyc(13); pll_locked_i = 1'b0; cyc(1); pll_locked_i = 1'b1;
      wait_release(60);
      chk("t2_fall_edge", 32'(fall_edge), 32'd33);
      cyc(3); pll_locked_i = 1'b0; cyc(1); pll_locked_i = 1'b1; cyc(3);
      chk("t2_run_drop", 32'(sys_rst_o), 32'd1);
      wait_sys_rst_low(60);

      // T3: short press rejected, long press accepted once, release without pulse
      rise0_cnt = 0;
      btn_i = 5'b00001; cyc(7); btn_i = '0; cyc(12);
      chk("t3_glitch_level", 32'(btn_level_o[0]), 32'd0);
      chk("t3_glitch_rise", 32'(rise0_cnt), 32'd0);
      btn_i = 5'b00001; cyc(12);
      chk("t3_press_level", 32'(btn_level_o[0]), 32'd1);
      chk("t3_press_rise", 32'(rise0_cnt), 32'd1);
      btn_i = '0; cyc(7);
      chk("t3_release_early", 32'(btn_level_o[0]), 32'd1);
      cyc(5);
      chk("t3_release_level", 32'(btn_level_o[0]), 32'd0);
      chk("t3_release_rise", 32'(rise0_cnt), 32'd1);

      // T4: enable mask, ack-with-rise keeps pending, lone ack clears
      irq_en_i = 5'b00001;
      btn_i = 5'b00011; cyc(14);
      chk("t4_pend", 32'(irq_pend_o), 32'h01);
      chk("t4_irq", 32'(irq_o), 32'd1);
      btn_i = '0; cyc(14);
      btn_i = 5'b00001;
      got_rise = 1'b0;
      for (int i = 0; i < 20 && !got_rise; i++) begin
         cyc(1);
         if (btn_rise_o[0] === 1'b1) got_rise = 1'b1;
      end
      chk("t4_rise_seen", 32'(got_rise), 32'd1);
      irq_ack_i = 5'b00001; cyc(1); irq_ack_i = '0; cyc(1);
      chk("t4_ack_with_rise", 32'(irq_pend_o), 32'h01);
      irq_ack_i = 5'b00001; cyc(1); irq_ack_i = '0; cyc(1);
      chk("t4_lone_ack_pend", 32'(irq_pend_o), 32'h00);
      chk("t4_lone_ack_irq", 32'(irq_o), 32'd0);
      btn_i = '0; cyc(14);

      // T6: reset mid-debounce with an IRQ pending
      btn_i = 5'b00001; cyc(14);
      btn_i = 5'b00101; cyc(4);
      srstn_i = 1'b0; cyc(1);
      chk("t6_sys_rst", 32'(sys_rst_o), 32'd1);
      chk("t6_level", 32'(btn_level_o), 32'h0);
      chk("t6_irq", 32'(irq_o), 32'd0);
      srstn_i = 1'b1; btn_i = '0;
      wait_sys_rst_low(60);

      // Randomised traffic, all checked by the scoreboard
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 19) == 0) btn_i = btn_i ^ BTN'(1 << $urandom_range(0, BTN - 1));
         if ($urandom_range(0, 99) == 0) irq_en_i = BTN'($urandom);
         irq_ack_i = ($urandom_range(0, 3) == 0) ? BTN'($urandom) : '0;
         if ($urandom_range(0, 3) == 0) sw_i = SW'($urandom);
         led_i = LED'($urandom);
         if ($urandom_range(0, 199) == 0) pll_locked_i = 1'b0;
         else if ($urandom_range(0, 3) == 0) pll_locked_i = 1'b1;
         if ($urandom_range(0, 299) == 0) ext_rstn_i = 1'b0;
         else if ($urandom_range(0, 3) == 0) ext_rstn_i = 1'b1;
         srstn_i = ($urandom_range(0, 399) != 0);
         cyc(1);
      end
      srstn_i = 1'b1;
      cyc(3);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
